// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared types and dimensions for the matrix-multiply array and
//               its result drain. Provides the array dimension, element
//               width, the drain index type, drain FSM states and the float
//               word shared with the compute units.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    localparam int N = 4;     // array dimension (N x N compute units)
    localparam int W = 32;    // element width, IEEE-754 single

    localparam int IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int RC_W  = (N > 1) ? $clog2(N) : 1;

    // Linear row-major index into the N x N result set.
    typedef logic [IDX_W-1:0] idx_t;

    // Raw IEEE-754 single word as produced by the compute units.
    typedef logic [W-1:0] float_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // Flat bit offset of unit (r,c) within a packed N*N*W bus.
    function automatic int unit_offset(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage : mm_pkg
`default_nettype wire

// File: rtl/result_snapshot.sv
`default_nettype none
// ============================================================================
// Module      : result_snapshot
// Description : N*N x (W+1) register bank holding one captured matrix result
//               (value plus overflow flag per unit). All entries load together
//               on a single enable; one combinational indexed read port.
// Ports       : clk          - clock, rising edge
//               i_load       - load every entry from i_data_flat / i_ovf
//               i_data_flat  - N*N*W packed values, unit k at [k*W +: W]
//               i_ovf        - N*N overflow flags, unit k at bit k
//               i_rd_idx     - row-major read index
//               o_rd_data    - value at i_rd_idx
//               o_rd_ovf     - overflow flag at i_rd_idx
// Revision    : 1.0 - initial release
// ============================================================================
module result_snapshot
    import mm_pkg::*;
#(
    parameter int N     = mm_pkg::N,
    parameter int W     = mm_pkg::W,
    parameter int IDX_W = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                 clk,
    input  logic                 i_load,
    input  logic [N*N*W-1:0]     i_data_flat,
    input  logic [N*N-1:0]       i_ovf,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [W-1:0]         o_rd_data,
    output logic                 o_rd_ovf
);

    // Bit W of each entry carries the overflow flag, bits W-1:0 the value.
    logic [W:0] r_bank [N*N];

    // The bank is a pure data store: it is never read while invalid, so it
    // carries no reset.
    generate
        for (genvar k = 0; k < N * N; k++) begin : g_entry
            always_ff @(posedge clk) begin
                if (i_load) begin
                    r_bank[k] <= {i_ovf[k], i_data_flat[k*W +: W]};
                end
            end
        end
    endgenerate

    logic [W:0] w_rd_entry;

    always_comb begin
        w_rd_entry = r_bank[i_rd_idx];
    end

    assign o_rd_data = w_rd_entry[W-1:0];
    assign o_rd_ovf  = w_rd_entry[W];

endmodule : result_snapshot
`default_nettype wire

// File: rtl/matrix_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : matrix_result_drain
// Description : Snapshots the C registers and overflow flags of an N x N
//               systolic array on a done pulse, pulses clr_acc so the array
//               can start the next product, and streams the snapshot out in
//               row-major order over a valid/ready port.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous, active-low
//               done         - one-cycle pulse, array results final
//               c_flat       - N*N*W packed C values, unit (r,c) at (r*N+c)*W
//               ovf_in       - N*N overflow flags, unit (r,c) at bit r*N+c
//               clr_acc      - one-cycle pulse clearing the array C registers
//               busy         - snapshot draining
//               out_data     - current element
//               out_row/col  - coordinates of out_data
//               out_overflow - overflow flag of current element
//               out_last     - current element is (N-1,N-1)
//               out_valid    - element presented
//               out_ready    - sink accepts
//               err_overflow - sticky: any captured overflow since reset
//               dropped      - sticky: a done was refused
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_result_drain
    import mm_pkg::*;
#(
    parameter int N = mm_pkg::N,
    parameter int W = mm_pkg::W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          done,
    input  logic [N*N*W-1:0]              c_flat,
    input  logic [N*N-1:0]                ovf_in,
    output logic                          clr_acc,
    output logic                          busy,
    output logic [W-1:0]                  out_data,
    output logic [((N>1)?$clog2(N):1)-1:0] out_row,
    output logic [((N>1)?$clog2(N):1)-1:0] out_col,
    output logic                          out_overflow,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err_overflow,
    output logic                          dropped
);

    localparam int L_IDX_W = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int L_RC_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [L_IDX_W-1:0] c_last_idx = L_IDX_W'(N * N - 1);
    localparam logic [L_IDX_W-1:0] c_one_idx  = L_IDX_W'(1);

    drain_state_t          r_state;
    logic [L_IDX_W-1:0]    r_idx;
    logic                  r_clr_acc;
    logic                  r_busy;
    logic [W-1:0]          r_out_data;
    logic [L_RC_W-1:0]     r_out_row;
    logic [L_RC_W-1:0]     r_out_col;
    logic                  r_out_overflow;
    logic                  r_out_last;
    logic                  r_out_valid;
    logic                  r_err_overflow;
    logic                  r_dropped;

    logic                  w_hs;
    logic                  w_final_hs;
    logic                  w_accept;
    logic [L_IDX_W-1:0]    w_next_idx;
    logic [L_RC_W-1:0]     w_next_row;
    logic [L_RC_W-1:0]     w_next_col;
    logic [W-1:0]          w_rd_data;
    logic                  w_rd_ovf;

    // A done is taken either from IDLE or on the very cycle the last element
    // of the current snapshot is handed off; anything else would overwrite
    // data still being drained.
    always_comb begin
        w_hs       = r_out_valid & out_ready;
        w_final_hs = w_hs && (r_idx == c_last_idx);
        w_accept   = done && ((r_state == IDLE) || w_final_hs);
        w_next_idx = (r_idx == c_last_idx) ? r_idx : (r_idx + c_one_idx);
        w_next_row = L_RC_W'(32'(w_next_idx) / N);
        w_next_col = L_RC_W'(32'(w_next_idx) % N);
    end

    // The read port looks one element ahead so the registered outputs can be
    // refreshed on the handshake edge with no bubble.
    result_snapshot #(
        .N     (N),
        .W     (W),
        .IDX_W (L_IDX_W)
    ) u_snapshot (
        .clk         (clk),
        .i_load      (w_accept),
        .i_data_flat (c_flat),
        .i_ovf       (ovf_in),
        .i_rd_idx    (w_next_idx),
        .o_rd_data   (w_rd_data),
        .o_rd_ovf    (w_rd_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_clr_acc      <= 1'b0;
            r_busy         <= 1'b0;
            r_out_data     <= '0;
            r_out_row      <= '0;
            r_out_col      <= '0;
            r_out_overflow <= 1'b0;
            r_out_last     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_err_overflow <= 1'b0;
            r_dropped      <= 1'b0;
        end else begin
            r_clr_acc <= 1'b0;

            if (done && !w_accept) begin
                r_dropped <= 1'b1;
            end

            if (w_accept) begin
                // Element (0,0) comes straight from the input bus because the
                // bank is being written on this same edge.
                r_state        <= DRAIN;
                r_idx          <= '0;
                r_clr_acc      <= 1'b1;
                r_busy         <= 1'b1;
                r_out_valid    <= 1'b1;
                r_out_data     <= c_flat[W-1:0];
                r_out_overflow <= ovf_in[0];
                r_out_row      <= '0;
                r_out_col      <= '0;
                r_out_last     <= (c_last_idx == '0);
                r_err_overflow <= r_err_overflow | (|ovf_in);
            end else if (w_final_hs) begin
                r_state        <= IDLE;
                r_idx          <= '0;
                r_busy         <= 1'b0;
                r_out_valid    <= 1'b0;
                r_out_last     <= 1'b0;
                r_out_overflow <= 1'b0;
            end else if (w_hs) begin
                r_idx          <= w_next_idx;
                r_out_data     <= w_rd_data;
                r_out_overflow <= w_rd_ovf;
                r_out_row      <= w_next_row;
                r_out_col      <= w_next_col;
                r_out_last     <= (w_next_idx == c_last_idx);
            end
        end
    end

    assign clr_acc      = r_clr_acc;
    assign busy         = r_busy;
    assign out_data     = r_out_data;
    assign out_row      = r_out_row;
    assign out_col      = r_out_col;
    assign out_overflow = r_out_overflow;
    assign out_last     = r_out_last;
    assign out_valid    = r_out_valid;
    assign err_overflow = r_err_overflow;
    assign dropped      = r_dropped;

endmodule : matrix_result_drain
`default_nettype wire

// File: tb/tb_matrix_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_result_drain
// Description : Self-checking bench for matrix_result_drain with N=2, W=32.
//               A queue-based model of the expected output stream is compared
//               against the DUT every cycle; directed scenarios add literal
//               expectations, followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_result_drain;

    localparam int N = 2;
    localparam int W = 32;

    logic               clk;
    logic               reset;
    logic               done;
    logic [N*N*W-1:0]   c_flat;
    logic [N*N-1:0]     ovf_in;
    logic               clr_acc;
    logic               busy;
    logic [W-1:0]       out_data;
    logic [0:0]         out_row;
    logic [0:0]         out_col;
    logic               out_overflow;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic               err_overflow;
    logic               dropped;

    int total = 0;
    int bad   = 0;

    matrix_result_drain #(
        .N (N),
        .W (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .done         (done),
        .c_flat       (c_flat),
        .ovf_in       (ovf_in),
        .clr_acc      (clr_acc),
        .busy         (busy),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_overflow (out_overflow),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .err_overflow (err_overflow),
        .dropped      (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of the elements still owed to the sink.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] d;
        logic        o;
        int          i;
    } ent_t;

    ent_t mq[$];
    bit   m_err, m_drop, m_clr, m_hs, m_acc;

    always @(posedge clk) begin : model
        if (!reset) begin
            mq.delete();
            m_err  = 1'b0;
            m_drop = 1'b0;
            m_clr  = 1'b0;
        end else begin
            m_hs  = (mq.size() > 0) && out_ready;
            m_acc = done && ((mq.size() == 0) || (m_hs && mq.size() == 1));
            if (m_hs) void'(mq.pop_front());
            m_clr = m_acc;
            if (m_acc) begin
                for (int k = 0; k < N * N; k++) begin
                    ent_t e;
                    e.d = c_flat[k*W +: W];
                    e.o = ovf_in[k];
                    e.i = k;
                    mq.push_back(e);
                end
                m_err = m_err | (|ovf_in);
            end else if (done) begin
                m_drop = 1'b1;
            end
        end
        #1;
        chk("valid", out_valid, (mq.size() > 0));
        chk("busy", busy, (mq.size() > 0));
        chk("clr_acc", clr_acc, m_clr);
        chk("err_overflow", err_overflow, m_err);
        chk("dropped", dropped, m_drop);
        if (!reset) begin
            chk("rst_data", out_data, 32'h0);
            chk("rst_last", out_last, 32'h0);
        end
        if (mq.size() > 0) begin
            chk("data", out_data, mq[0].d);
            chk("ovf", out_overflow, mq[0].o);
            chk("row", out_row, mq[0].i / N);
            chk("col", out_col, mq[0].i % N);
            chk("last", out_last, (mq[0].i == N * N - 1));
        end else begin
            chk("last_idle", out_last, 32'h0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [N*N*W-1:0] c_data_a =
        {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [N*N*W-1:0] c_data_b =
        {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};

    // Drives one done pulse; returns at the negedge after the accepting edge.
    task automatic pulse_done(input logic [N*N*W-1:0] d, input logic [N*N-1:0] o);
        @(negedge clk);
        c_flat = d;
        ovf_in = o;
        done   = 1'b1;
        @(negedge clk);
        done   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", busy, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : stim
        int cnt;
        reset     = 1'b0;
        done      = 1'b0;
        c_flat    = '0;
        ovf_in    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", out_valid, 32'h0);
        chk("reset_err", err_overflow, 32'h0);
        reset = 1'b1;

        // Basic drain
        out_ready = 1'b1;
        pulse_done(c_data_a, 4'b0000);
        chk("b_clr", clr_acc, 32'h1);
        chk("b_d0", out_data, 32'h3F800000);
        chk("b_rc0", {out_row, out_col}, 32'h0);
        @(negedge clk);
        chk("b_clr_low", clr_acc, 32'h0);
        chk("b_d1", out_data, 32'h40000000);
        chk("b_rc1", {out_row, out_col}, 32'h1);
        @(negedge clk);
        chk("b_d2", out_data, 32'h40400000);
        chk("b_rc2", {out_row, out_col}, 32'h2);
        chk("b_last2", out_last, 32'h0);
        @(negedge clk);
        chk("b_d3", out_data, 32'h40800000);
        chk("b_last3", out_last, 32'h1);
        @(negedge clk);
        chk("b_idle", {out_valid, busy, out_last}, 32'h0);

        // Backpressure: ready low for 3 cycles while (0,1) is presented
        pulse_done(c_data_a, 4'b0000);
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (cnt >= 2 && cnt <= 4) begin
                out_ready = 1'b0;
                chk("bp_hold", out_data, 32'h40000000);
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("bp_cycles", cnt, 7);
        out_ready = 1'b1;

        // Overflow capture, then a clean snapshot
        pulse_done(c_data_a, 4'b0100);
        chk("ov_err", err_overflow, 32'h1);
        wait_idle();
        pulse_done(c_data_b, 4'b0000);
        wait_idle();
        chk("ov_sticky", err_overflow, 32'h1);

        // Done collision at idx=1
        pulse_done(c_data_a, 4'b0000);
        @(negedge clk);
        c_flat = c_data_b;
        done   = 1'b1;
        @(negedge clk);
        done   = 1'b0;
        chk("col_dropped", dropped, 32'h1);
        chk("col_d2", out_data, 32'h40400000);
        wait_idle();

        // Reset mid-drain at idx=2
        pulse_done(c_data_a, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_outs", {clr_acc, busy, out_overflow, out_last, out_valid,
                          err_overflow, dropped, out_row, out_col}, 32'h0);
        chk("arst_data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        pulse_done(c_data_a, 4'b0000);
        chk("arst_redo", out_data, 32'h3F800000);
        chk("arst_rc", {out_row, out_col}, 32'h0);
        wait_idle();

        // Back-to-back accept on the final handshake
        pulse_done(c_data_a, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("bb_last", out_last, 32'h1);
        c_flat = c_data_b;
        done   = 1'b1;
        @(negedge clk);
        done   = 1'b0;
        chk("bb_valid", out_valid, 32'h1);
        chk("bb_d0", out_data, 32'h40A00000);
        chk("bb_clr", clr_acc, 32'h1);
        chk("bb_dropped", dropped, 32'h0);
        wait_idle();

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            done      = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            c_flat    = {$urandom(), $urandom(), $urandom(), $urandom()};
            ovf_in    = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'b0000;
        end
        @(negedge clk);
        done      = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_matrix_result_drain
`default_nettype wire
